// File: rtl/grad_pkg.sv
// rtl/grad_pkg.sv - Shared sizes, FSM state type and Sobel/direction helpers for grad_dir_gen
package grad_pkg;

    localparam int IMG_W     = 512;
    localparam int IMG_H     = 512;
    localparam int FILL_LAT  = 513;
    localparam int PIPE_LAT  = 3;
    localparam int MAG_SHIFT = 2;
    localparam int ADDR_W    = 18;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    // tan(10*k degrees) scaled by 1024
    function automatic logic [12:0] t_thresh(input logic [3:0] k);
        case (k)
            4'd1:    t_thresh = 13'd181;
            4'd2:    t_thresh = 13'd373;
            4'd3:    t_thresh = 13'd591;
            4'd4:    t_thresh = 13'd859;
            4'd5:    t_thresh = 13'd1220;
            4'd6:    t_thresh = 13'd1774;
            4'd7:    t_thresh = 13'd2813;
            4'd8:    t_thresh = 13'd5807;
            default: t_thresh = 13'd0;
        endcase
    endfunction

    function automatic logic signed [10:0] sobel_diff(
        input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
        input logic [7:0] d, input logic [7:0] e, input logic [7:0] f
    );
        logic [10:0] pos;
        logic [10:0] neg;
        pos = {3'b000, a} + {2'b00, b, 1'b0} + {3'b000, c};
        neg = {3'b000, d} + {2'b00, e, 1'b0} + {3'b000, f};
        return $signed(pos - neg);
    endfunction

    function automatic logic [3:0] angle_q(input logic [10:0] ax, input logic [10:0] ay);
        logic [22:0] lhs;
        logic [22:0] rhs;
        logic [3:0]  q;
        lhs = {2'b00, ay, 10'b0};
        q   = 4'd0;
        for (int k = 1; k <= 8; k++) begin
            rhs = {12'b0, ax} * {10'b0, t_thresh(4'(k))};
            if (lhs >= rhs) q = q + 4'd1;
        end
        return q;
    endfunction

    function automatic logic [5:0] dir_bin(input logic [3:0] q, input logic gx_neg, input logic gy_neg);
        case ({gx_neg, gy_neg})
            2'b00:   dir_bin = {2'b00, q};
            2'b10:   dir_bin = 6'd17 - {2'b00, q};
            2'b11:   dir_bin = 6'd18 + {2'b00, q};
            default: dir_bin = 6'd35 - {2'b00, q};
        endcase
    endfunction

endpackage

// File: rtl/grad_dir_gen_if.sv
// rtl/grad_dir_gen_if.sv - Pixel-in / gradient-out signal bundle for grad_dir_gen
interface grad_dir_gen_if;
    import grad_pkg::*;

    logic              start;
    logic              pix_valid;
    logic [7:0]        pix;
    logic              pix_ready;
    logic [7:0]        mag;
    logic [5:0]        dir;
    logic              out_valid;
    logic [ADDR_W-1:0] out_addr;
    logic              frame_done;

    modport master (
        output start, pix_valid, pix,
        input  pix_ready, mag, dir, out_valid, out_addr, frame_done
    );

    modport slave (
        input  start, pix_valid, pix,
        output pix_ready, mag, dir, out_valid, out_addr, frame_done
    );

endinterface

// File: rtl/grad_line_buf.sv
// rtl/grad_line_buf.sv - Two-line pixel delay: returns the pixels one and two rows above the write index
module grad_line_buf #(
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic [AW-1:0] i_idx,
    input  logic [7:0]    i_pix,
    output logic [7:0]    o_l1,
    output logic [7:0]    o_l2
);

    logic [7:0] r_line1 [DEPTH];
    logic [7:0] r_line2 [DEPTH];

    assign o_l1 = r_line1[i_idx];
    assign o_l2 = r_line2[i_idx];

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_line1[i_idx] <= i_pix;
            r_line2[i_idx] <= r_line1[i_idx];
        end
    end

endmodule

// File: rtl/grad_dir_gen.sv
// rtl/grad_dir_gen.sv - Streaming 3x3 Sobel magnitude and 10-degree direction bins over a raster frame
module grad_dir_gen
    import grad_pkg::*;
#(
    parameter int P_IMG_W    = IMG_W,
    parameter int P_IMG_H    = IMG_H,
    parameter int P_FILL_LAT = FILL_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pix_valid,
    input  logic [7:0]        pix,
    output logic              pix_ready,
    output logic [7:0]        mag,
    output logic [5:0]        dir,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic              frame_done
);

    localparam int XW = $clog2(P_IMG_W);
    localparam int YW = $clog2(P_IMG_H);
    localparam logic [ADDR_W-1:0] LAST_ACC  = ADDR_W'(P_IMG_W * P_IMG_H - 1);
    localparam logic [ADDR_W-1:0] FILL      = ADDR_W'(P_FILL_LAT);
    localparam logic [ADDR_W-1:0] LAST_FLSH = ADDR_W'(P_FILL_LAT - 1);
    localparam logic [XW-1:0]     LAST_X    = XW'(P_IMG_W - 1);
    localparam logic [YW-1:0]     LAST_Y    = YW'(P_IMG_H - 1);

    state_t            r_state, w_state_nx;
    logic              w_acc, w_issue, w_border;
    logic [ADDR_W-1:0] r_acc, r_flush, r_caddr;
    logic [XW-1:0]     r_col, r_ccol;
    logic [YW-1:0]     r_crow;
    logic [7:0]        w_l1, w_l2;

    always_comb begin
        w_state_nx = r_state;
        w_acc      = 1'b0;
        w_issue    = 1'b0;
        pix_ready  = 1'b0;
        frame_done = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_state_nx = S_RUN;
            S_RUN: begin
                pix_ready = 1'b1;
                if (pix_valid) begin
                    w_acc   = 1'b1;
                    w_issue = (r_acc >= FILL);
                    if (r_acc == LAST_ACC) w_state_nx = S_FLUSH;
                end
            end
            S_FLUSH: begin
                w_issue = 1'b1;
                if (r_flush == LAST_FLSH) w_state_nx = S_DONE;
            end
            default: begin
                frame_done = 1'b1;
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    // Centre coordinates are tracked separately so border detection needs no division
    always_ff @(posedge clk) begin
        if (rst || r_state == S_IDLE) begin
            r_acc   <= '0;
            r_col   <= '0;
            r_flush <= '0;
            r_caddr <= '0;
            r_ccol  <= '0;
            r_crow  <= '0;
        end else begin
            if (w_acc) begin
                r_acc <= r_acc + 1'b1;
                r_col <= (r_col == LAST_X) ? '0 : r_col + 1'b1;
            end
            if (r_state == S_FLUSH) r_flush <= r_flush + 1'b1;
            if (w_issue) begin
                r_caddr <= r_caddr + 1'b1;
                if (r_ccol == LAST_X) begin
                    r_ccol <= '0;
                    r_crow <= r_crow + 1'b1;
                end else begin
                    r_ccol <= r_ccol + 1'b1;
                end
            end
        end
    end

    assign w_border = (r_crow == '0) || (r_crow == LAST_Y) || (r_ccol == '0) || (r_ccol == LAST_X);

    grad_line_buf #(.DEPTH(P_IMG_W), .AW(XW)) u_line_buf (
        .clk   (clk),
        .i_en  (w_acc),
        .i_idx (r_col),
        .i_pix (pix),
        .o_l1  (w_l1),
        .o_l2  (w_l2)
    );

    // Stage 0: window shifts only on accepts; flush slots only ever issue border centres
    logic [7:0]        r_win [3][3];
    logic              r_v0, r_b0;
    logic [ADDR_W-1:0] r_a0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    r_win[r][c] <= '0;
            r_v0 <= 1'b0;
            r_b0 <= 1'b0;
            r_a0 <= '0;
        end else begin
            if (w_acc) begin
                for (int r = 0; r < 3; r++) begin
                    r_win[r][0] <= r_win[r][1];
                    r_win[r][1] <= r_win[r][2];
                end
                r_win[0][2] <= w_l2;
                r_win[1][2] <= w_l1;
                r_win[2][2] <= pix;
            end
            r_v0 <= w_issue;
            r_b0 <= w_border;
            r_a0 <= r_caddr;
        end
    end

    logic signed [10:0] r_gx, r_gy;
    logic               r_v1, r_b1;
    logic [ADDR_W-1:0]  r_a1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gx <= '0;
            r_gy <= '0;
            r_v1 <= 1'b0;
            r_b1 <= 1'b0;
            r_a1 <= '0;
        end else begin
            r_gx <= sobel_diff(r_win[0][2], r_win[1][2], r_win[2][2], r_win[0][0], r_win[1][0], r_win[2][0]);
            r_gy <= sobel_diff(r_win[2][0], r_win[2][1], r_win[2][2], r_win[0][0], r_win[0][1], r_win[0][2]);
            r_v1 <= r_v0;
            r_b1 <= r_b0;
            r_a1 <= r_a0;
        end
    end

    logic [10:0] w_ax, w_ay, w_sum, w_shr;
    logic [7:0]  w_mag;

    always_comb begin
        w_ax  = r_gx[10] ? 11'(-r_gx) : 11'(r_gx);
        w_ay  = r_gy[10] ? 11'(-r_gy) : 11'(r_gy);
        w_sum = w_ax + w_ay;
        w_shr = w_sum >> MAG_SHIFT;
        w_mag = (w_shr > 11'd255) ? 8'd255 : w_shr[7:0];
    end

    logic [7:0]        r_mag;
    logic [5:0]        r_dir;
    logic              r_out_valid;
    logic [ADDR_W-1:0] r_out_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mag       <= '0;
            r_dir       <= '0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
        end else begin
            r_out_valid <= r_v1;
            r_out_addr  <= r_a1;
            if (r_b1 || (r_gx == '0 && r_gy == '0)) begin
                r_mag <= '0;
                r_dir <= '0;
            end else begin
                r_mag <= w_mag;
                r_dir <= dir_bin(angle_q(w_ax, w_ay), r_gx[10], r_gy[10]);
            end
        end
    end

    assign mag       = r_mag;
    assign dir       = r_dir;
    assign out_valid = r_out_valid;
    assign out_addr  = r_out_addr;

endmodule

// File: doc/grad_dir_gen.md
GRAD_DIR_GEN -- requirements
Module: grad_dir_gen

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port start, input, 1, single-cycle pulse that arms a frame; it is honoured only in IDLE.
REQ-004 SHALL have port pix_valid, input, 1, pixel present on pix.
REQ-005 SHALL have port pix, input, 8, grey pixel, raster order, 512x512.
REQ-006 SHALL have port pix_ready, output, 1, pixel accepted when pix_valid&&pix_ready.
REQ-007 SHALL have port mag, output, 8, gradient magnitude of the centre pixel.
REQ-008 SHALL have port dir, output, 6, direction bin 0..35 (10 degrees per bin).
REQ-009 SHALL have port out_valid, output, 1, mag/dir/out_addr valid; there is no backpressure.
REQ-010 SHALL have port out_addr, output, 18, raster index of the centre pixel.
REQ-011 SHALL have port frame_done, output, 1, one-cycle pulse after the last emission.

Function
REQ-012 SHALL implement FSM IDLE->RUN on start; RUN->FLUSH after accept index 262143; FLUSH->DONE after 513 flush slots; DONE->IDLE in the next cycle, with frame_done=1 in the DONE cycle.
REQ-013 SHALL drive pix_ready=1 only in RUN.
REQ-014 SHALL count accepts k=0..262143; accept k>=513 issues centre k-513; each FLUSH cycle issues one centre, 261631..262143 ascending; every centre 0..262143 is issued exactly once, in order.
REQ-015 SHALL drive out_valid 3 cycles after the issuing accept or flush slot, with the matching out_addr; out_valid=0 otherwise.
REQ-016 SHALL number the 3x3 window p1..p9 row-major with p1 at the top-left and p5 at the centre, held in two 512x8 line buffers plus window registers.
REQ-017 SHALL compute gx=(p3+2p6+p9)-(p1+2p4+p7) and gy=(p7+2p8+p9)-(p1+2p2+p3), each 11-bit signed.
REQ-018 SHALL compute mag=min(255,(|gx|+|gy|)>>2).
REQ-019 SHALL, with ax=|gx| and ay=|gy|, set q = the number of k in 1..8 with ay*1024 >= ax*T[k]; T = 181, 373, 591, 859, 1220, 1774, 2813, 5807; products are at least 23 bits unsigned.
REQ-020 SHALL set dir = q if gx>=0,gy>=0; 17-q if gx<0,gy>=0; 18+q if gx<0,gy<0; 35-q if gx>=0,gy<0.
REQ-021 SHALL emit mag=0, dir=0 when gx=gy=0.
REQ-022 SHALL emit mag=0, dir=0 for border centres (row 0, row 511, col 0, col 511).
REQ-023 SHALL advance no state on a RUN cycle with pix_valid=0; the pipeline drains what is already issued.
REQ-024 SHALL ignore start outside IDLE.

Reset
REQ-025 SHALL, on rst=1, go to IDLE, clear counters and the pipeline, and drive pix_ready=0, out_valid=0, mag=0, dir=0, out_addr=0, frame_done=0 from the next edge.
REQ-026 SHALL, on rst mid-frame, discard the in-flight frame; no out_valid and no frame_done follow until a new start.
REQ-027 SHALL leave line-buffer contents unreset; they are never read before being written in a frame.

Structure
REQ-028 SHALL take IMG_W=512, IMG_H=512, FILL_LAT=513, PIPE_LAT=3, MAG_SHIFT=2 and the T[1..8] table from shared package grad_pkg.
REQ-029 SHALL instantiate one sub-module, grad_line_buf (two-line 512x8 delay buffer with single write/read index).
REQ-030 SHALL total 120-400 RTL lines.

Verification
REQ-031 SHALL cover: flat image of 100, continuous valid -> 262144 outputs, all mag=0 dir=0, addr 0..262143 ascending, one frame_done.
REQ-032 SHALL cover: vertical step, pix=0 for col<256 and 200 otherwise -> centre (100,255) and (100,256): mag=200, dir=0; centre (100,10): mag=0.
REQ-033 SHALL cover: horizontal step, pix=0 for row<256 and 50 otherwise -> centre (255,100): mag=50, dir=8; inverted vertical step (200 then 0) -> centre (100,255): mag=200, dir=17.
REQ-034 SHALL cover: diagonal, pix=200 if row+col>=512 else 0 -> centre (300,211): gx=gy=600, mag=255 (saturated), dir=4.
REQ-035 SHALL cover: random pix_valid gaps (~30% idle) -> outputs identical in value and order to the continuous run; out_valid exactly 3 cycles after each issuing accept.
REQ-036 SHALL cover: rst at accept 100000 -> outputs zero next cycle, no frame_done; a new start then gives a full correct frame.
